regwb_arb: RTL
==============

# regwb_arb

Write-port arbiter for the 32×32 register bank. It merges two writeback sources onto the bank's single write port: source A is the ALU writeback and source B is the load/mul-div writeback. Each source gets a one-entry holding slot behind a valid/ready handshake. The block preserves write-after-write order to the same register and publishes a pending-write mask for the hazard/stall logic.

## Interface
- No parameters. Widths are fixed: register address 5 bits, data 32 bits.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- a_valid  in  1  source A (ALU) has a write
- a_ready  out  1  source A slot can accept
- a_reg  in  5  source A destination register
- a_data  in  32  source A write data
- b_valid  in  1  source B (load/mul-div) has a write
- b_ready  out  1  source B slot can accept
- b_reg  in  5  source B destination register
- b_data  in  32  source B write data
- regwrite  out  1  write enable to register bank (registered)
- wrreg  out  5  write address to register bank (registered)
- wrdata  out  32  write data to register bank (registered)
- pend_mask  out  32  bit r set while a write to register r is in flight

## Operation
- Transfers:
  - A transfer on source X occurs when X_valid and X_ready are both high at a rising edge.
  - The transfer loads slot X with {reg, data} and sets slot X full.
- X_ready = !slot_X_full || grant_X. A slot issuing this cycle can accept a new entry in the same cycle.
- Age tracking:
  - An age bit records which full slot was loaded first.
  - On simultaneous load into two empty slots, A is older.
- Eligibility:
  - A full slot is eligible unless the other slot is full, targets the same register, and is older.
  - This preserves write-after-write order.
- Grant: at most one slot per cycle, combinational from slot state.
  - One eligible slot: that slot is granted.
  - Two eligible slots (distinct registers): policy per Configuration.
- Issue: on grant, at the edge the output flops load regwrite=(reg!=0), wrreg, wrdata, and the granted slot clears unless reloaded.
- No grant means regwrite=0 next cycle; wrreg and wrdata hold their last values.
- Writes to register 0 are accepted, consume a grant, and never raise regwrite.
- pend_mask[r] is the OR of:
  - slot A full with reg r
  - slot B full with reg r
  - output stage regwrite high with wrreg r
- pend_mask[0] is always 0.

## Timing
- Reset (rst_n=0 at an edge):
  - Both slots are emptied, the age bit is cleared and the RR pointer is set to A.
  - Outputs: regwrite=0, wrreg=0, wrdata=0, pend_mask=0.
  - a_ready=b_ready=1 from the first cycle after reset.
  - Reset mid-operation discards buffered writes; nothing is written afterwards.
- Latency from accept at edge N:
  - Slot full during cycle N+1. If granted there, regwrite is high during cycle N+2 and the bank captures at the end of N+2.
  - Minimum accept-to-bank-update latency is 2 cycles.
- Throughput: one bank write per cycle sustained. One source can stream back-to-back at 1/cycle when the other is idle.
- With both sources streaming, aggregate throughput is 1/cycle. The losing source sees ready low while its slot is full and not granted.
- pend_mask timing: set from cycle N+1 through the last cycle regwrite is high for that write, inclusive.
- Same-register conflict: the older slot issues, then the younger slot issues in the next cycle. Bank writes are consecutive and in order.
- Inputs X_reg and X_data are sampled only on a transfer. Values while X_valid=0 are ignored.

## Configuration
- REGWB_RR_EN defined:
  - When both slots are eligible, round-robin applies: grant goes to the slot not granted most recently.
  - The pointer updates on every grant.
- REGWB_RR_EN undefined: fixed priority, B wins over A whenever both are eligible.
- Age ordering for same-register conflicts overrides either policy.

## Test plan
- Single write, regs empty:
  - Stimulus: a_valid=1, a_reg=5, a_data=0xDEADBEEF for one cycle at edge N.
  - Required: regwrite=1, wrreg=5, wrdata=0xDEADBEEF during cycle N+2 only.
  - Required: pend_mask=0x20 during N+1..N+2, and 0 afterwards.
- Simultaneous distinct writes:
  - Stimulus: A reg 3 = 0x11 and B reg 4 = 0x22 at the same edge.
  - Required without REGWB_RR_EN: reg 4 written in cycle N+2, reg 3 in N+3, a_ready=0 during N+1.
  - Required with REGWB_RR_EN from reset: reg 3 written first.
- WAW ordering:
  - Stimulus: B reg 7 = 0xAA at edge N while the output stage is busy, then A reg 7 = 0xBB at edge N+1.
  - Required: bank sees 0xAA then 0xBB in consecutive cycles, in either macro setting.
- Register 0:
  - Stimulus: A writes reg 0 = 0xFFFF_FFFF.
  - Required: the write is accepted, regwrite stays 0, and pend_mask stays 0.
- Sustained contention with REGWB_RR_EN:
  - Stimulus: both sources valid for 20 cycles with distinct registers.
  - Required: grants alternate A/B, 20 writes are issued, and neither source stalls more than 1 consecutive cycle.
- Reset mid-operation:
  - Stimulus: both slots full, then rst_n=0 for one edge.
  - Required: the next cycle shows regwrite=0, pend_mask=0 and both readies 1. No buffered write ever reaches the bank.

Source files
------------

// File: rtl/regwb_arb.sv
`default_nettype none
// ============================================================================
// Module   : regwb_arb
// Purpose  : Two-source writeback arbiter for the 32x32 register bank.
//            Each source has a one-entry slot. Same-register writes keep
//            their arrival order. Optional macro REGWB_RR_EN selects
//            round-robin between eligible slots; otherwise B has priority.
// Revision : 1.0  initial release
// ============================================================================
module regwb_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata,
    output logic [31:0] pend_mask
);

    logic        a_full, b_full;
    logic [4:0]  a_reg_q, b_reg_q;
    logic [31:0] a_data_q, b_data_q;
    logic        a_older;
    logic        same_reg;
    logic        elig_a, elig_b;
    logic        grant_a, grant_b;
    logic        a_load, b_load;
    logic        a_keep, b_keep;

    assign same_reg = (a_reg_q == b_reg_q);

    // A slot holding a younger write to the same register must wait.
    assign elig_a = a_full && !(b_full && same_reg && !a_older);
    assign elig_b = b_full && !(a_full && same_reg && a_older);

`ifdef REGWB_RR_EN
    logic prio_a;

    assign grant_a = elig_a && (!elig_b || prio_a);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_a <= 1'b1;
        end else if (grant_a) begin
            prio_a <= 1'b0;
        end else if (grant_b) begin
            prio_a <= 1'b1;
        end
    end
`else
    assign grant_a = elig_a && !elig_b;
`endif

    assign grant_b = elig_b && !grant_a;

    assign a_ready = !a_full || grant_a;
    assign b_ready = !b_full || grant_b;
    assign a_load  = a_valid && a_ready;
    assign b_load  = b_valid && b_ready;
    assign a_keep  = a_full && !grant_a;
    assign b_keep  = b_full && !grant_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_full   <= 1'b0;
            b_full   <= 1'b0;
            a_reg_q  <= 5'd0;
            b_reg_q  <= 5'd0;
            a_data_q <= 32'd0;
            b_data_q <= 32'd0;
            a_older  <= 1'b0;
        end else begin
            if (a_load) begin
                a_full   <= 1'b1;
                a_reg_q  <= a_reg;
                a_data_q <= a_data;
            end else if (grant_a) begin
                a_full <= 1'b0;
            end

            if (b_load) begin
                b_full   <= 1'b1;
                b_reg_q  <= b_reg;
                b_data_q <= b_data;
            end else if (grant_b) begin
                b_full <= 1'b0;
            end

            // The entry that stays behind is older than a newcomer; a tie goes to A.
            if (a_keep && b_load) begin
                a_older <= 1'b1;
            end else if (b_keep && a_load) begin
                a_older <= 1'b0;
            end else if (a_load && b_load) begin
                a_older <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            wrreg    <= 5'd0;
            wrdata   <= 32'd0;
        end else if (grant_a) begin
            regwrite <= (a_reg_q != 5'd0);
            wrreg    <= a_reg_q;
            wrdata   <= a_data_q;
        end else if (grant_b) begin
            regwrite <= (b_reg_q != 5'd0);
            wrreg    <= b_reg_q;
            wrdata   <= b_data_q;
        end else begin
            regwrite <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        if (a_full) begin
            pend_mask = pend_mask | (32'd1 << a_reg_q);
        end
        if (b_full) begin
            pend_mask = pend_mask | (32'd1 << b_reg_q);
        end
        if (regwrite) begin
            pend_mask = pend_mask | (32'd1 << wrreg);
        end
        pend_mask[0] = 1'b0;
    end

endmodule
`default_nettype wire
